// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// Loads the instruction memory from a length-prefixed byte stream and holds the core in reset meanwhile.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold,
  output logic [8:0]          words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  // Where the image goes once the last word (or an empty header) is through.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CKSUM;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        ck_total;
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        last_word;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign hdr_n     = {bus.in_data, count_q[7:0]};
  assign last_word = (({7'd0, words_q} + 16'd1) == count_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ck_total  = sum_q + bus.in_data;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    wd_d       = wd_q;
    addr_d     = addr_q;
    words_d    = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_LO;
          addr_d     = '0;
          words_d    = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = bus.in_data;
          state_d      = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          count_d = hdr_n;
          if (hdr_n == 16'd0)
            state_d = S_FINISH;
          else if (hdr_n > 16'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          // Shifting in from the top leaves the first byte of the word in [7:0].
          wd_d       = {bus.in_data, wd_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + bus.in_data;
`endif
          if (byte_cnt_q == 2'd3)
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        words_d = words_q + 9'd1;
        state_d = last_word ? S_FINISH : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (xfer)
          state_d = (ck_total == 8'd0) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      byte_cnt_q <= '0;
      wd_q       <= '0;
      addr_q     <= '0;
      words_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      wd_q       <= wd_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Every output is a register or a pure decode of the state.
  always_comb begin
    bus.in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_q == S_CKSUM)
      bus.in_ready = 1'b1;
`endif
  end

  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wd    = wd_q;
  assign busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign cpu_hold      = (state_q != S_DONE);
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes are derived from the byte stream itself.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, error, cpu_hold;
  logic [8:0] words_loaded;

  imem_loader_if #(.ADDR_W(10)) intf ();

  imem_loader #(.ADDR_W(10), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (intf.master),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          gap_max = 0;
  int          ready_during_we = 0;
  logic [7:0]  data_q[$];
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_wd_q[$];

  // Records every memory write as the memory would see it.
  always @(negedge clk) begin
    if (intf.mem_we === 1'b1) begin
      wr_addr_q.push_back(intf.mem_addr);
      wr_wd_q.push_back(intf.mem_wd);
      if (intf.in_ready !== 1'b0) ready_during_we++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    intf.in_valid = 1'b1;
    intf.in_data  = b;
    while (intf.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_total++;
      $error("FAIL ready_timeout observed in_ready=%b expected=1", intf.in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    intf.in_valid = 1'b0;
    intf.in_data  = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"}, intf.in_ready, 0);
    chk({pfx, "_mem_we"},   intf.mem_we, 0);
    chk({pfx, "_mem_addr"}, intf.mem_addr, 0);
    chk({pfx, "_mem_wd"},   intf.mem_wd, 0);
    chk({pfx, "_busy"},     busy, 0);
    chk({pfx, "_done"},     done, 0);
    chk({pfx, "_error"},    error, 0);
    chk({pfx, "_cpu_hold"}, cpu_hold, 1);
    chk({pfx, "_words"},    words_loaded, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One complete load of n_hdr words taken from data_q; checks final status and every write.
  task automatic run_load(input string tag, input int n_hdr, input bit bad_ck);
    int         nw;
    bit         exp_err;
    logic [7:0] sum;
    logic [31:0] exp_wd;
    wr_addr_q.delete();
    wr_wd_q.delete();
    ready_during_we = 0;
    pulse_start();
    send_byte(n_hdr[7:0]);
    send_byte(n_hdr[15:8]);
    exp_err = (n_hdr > 256);
    nw      = exp_err ? 0 : n_hdr;
    sum     = 8'd0;
    if (!exp_err) begin
      for (int i = 0; i < 4 * nw; i++) begin
        send_byte(data_q[i]);
        sum = sum + data_q[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_ck ? 8'(8'h00 - sum + 8'h01) : 8'(8'h00 - sum));
      exp_err = bad_ck;
`else
      if (nw > 0) begin
        chk({tag, "_last_we"}, intf.mem_we, 1);
        @(posedge clk);
        #1;
      end
`endif
    end
    chk({tag, "_done"},     done, !exp_err);
    chk({tag, "_error"},    error, exp_err);
    chk({tag, "_cpu_hold"}, cpu_hold, exp_err);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_words"},    words_loaded, nw);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_held_done"},  done, !exp_err);
    chk({tag, "_held_error"}, error, exp_err);
    chk({tag, "_idle_ready"}, intf.in_ready, 0);
    chk({tag, "_wr_count"},   wr_wd_q.size(), nw);
    chk({tag, "_ready_we"},   ready_during_we, 0);
    for (int k = 0; k < nw && k < wr_wd_q.size(); k++) begin
      exp_wd = 32'(data_q[4*k]) + (32'(data_q[4*k+1]) << 8)
             + (32'(data_q[4*k+2]) << 16) + (32'(data_q[4*k+3]) << 24);
      chk($sformatf("%s_wr%0d_addr", tag, k), wr_addr_q[k], 4 * k);
      chk($sformatf("%s_wr%0d_wd", tag, k), wr_wd_q[k], exp_wd);
    end
    $display("load %s: N=%0d writes=%0d done=%b error=%b", tag, n_hdr, wr_wd_q.size(), done, error);
  endtask

  task automatic fill_random(input int nbytes);
    data_q.delete();
    for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
  endtask

  initial begin
    intf.in_valid = 1'b0;
    intf.in_data  = 8'h00;
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic two-word image from fixed bytes.
    data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load("basic", 2, 1'b0);
    if (wr_wd_q.size() == 2) begin
      chk("basic_word0", wr_wd_q[0], 32'h0000_0013);
      chk("basic_word1", wr_wd_q[1], 32'h0010_0093);
    end

    run_load("empty", 0, 1'b0);
    run_load("oversize", 257, 1'b0);

    gap_max = 2;
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(4 * n);
      run_load($sformatf("rand%0d", r), n, 1'b0);
    end

    gap_max = 3;
    fill_random(1024);
    run_load("full", 256, 1'b0);
    if (wr_addr_q.size() == 256) chk("full_last_addr", wr_addr_q[255], 10'h3FC);

    // Reset in the middle of a word: no write may escape, then a fresh load works.
    gap_max = 0;
    wr_addr_q.delete();
    wr_wd_q.delete();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_write", wr_wd_q.size(), 0);
    $display("load midrst: reset after 2 data bytes writes=%0d", wr_wd_q.size());
    fill_random(4);
    run_load("after_rst", 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load("ck_good", 1, 1'b0);
    run_load("ck_bad", 1, 1'b1);
    if (wr_wd_q.size() == 1) chk("ck_bad_word", wr_wd_q[0], 32'h0403_0201);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the byte-addressed instruction memory of the single-cycle RISC-V core from an external 8-bit byte stream, typically a UART receiver. It parses a length header, assembles little-endian 32-bit words and issues one word write per four bytes on the memory's write port (`WE`/`A`/`WD`). It holds the core in reset until the image is complete. It sits between the byte source and the instruction memory write side; the core only reads that memory.

## Interface
- `ADDR_W`, 10: byte-address width of the instruction memory.
- `MAX_WORDS`, 256: largest accepted word count; equals 2^ADDR_W / 4.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: arms the loader; sampled only in IDLE, DONE and ERR.
- `in_valid`  in  1: `in_data` is valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle. A transfer occurs when `in_valid` and `in_ready` are both 1.
- `mem_we`  out  1: instruction memory write enable; one-cycle pulse per word.
- `mem_addr`  out  ADDR_W: word-aligned byte address; bits [1:0] are always 0.
- `mem_wd`  out  32: assembled word.
- `busy`  out  1: high in every state except IDLE, DONE and ERR.
- `done`  out  1: image loaded successfully; held until the next `start`.
- `error`  out  1: load aborted; held until the next `start`.
- `cpu_hold`  out  1: core reset request; 0 only in DONE.
- `words_loaded`  out  9: count of words written in the current load.

## Operation
- Stream format: count low byte, count high byte (N, 16-bit), then 4N data bytes. Each word is sent LSB first: byte 0 goes to `mem_wd[7:0]` and byte 3 goes to `mem_wd[31:24]`.
- States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, CKSUM (only with the macro), DONE, ERR.
- IDLE to HDR_LO when `start`=1.
- HDR_LO: capture the low byte of N on transfer, then go to HDR_HI.
- HDR_HI: capture the high byte of N on transfer, then branch on N:
  - N=0: go to DONE (or CKSUM with the macro).
  - N>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: shift each transferred byte into its lane using a 2-bit byte counter. On the 4th byte, go to WRITE.
- WRITE:
  - `mem_we`=1 and `in_ready`=0 for exactly one cycle.
  - Next cycle: `mem_addr` += 4 and `words_loaded` += 1.
  - If `words_loaded`+1 == N, go to DONE (or CKSUM with the macro); otherwise go back to DATA.
- DONE or ERR: `start` restarts at HDR_LO. It clears `mem_addr`, `words_loaded`, the byte counter, `done` and `error`.
- `start` in any busy state is ignored.
- Address never wraps, because N ≤ MAX_WORDS. The final write of a full image is at 0x3FC.
- `in_ready`=1 only in HDR_LO, HDR_HI, DATA and CKSUM.
- `in_valid` may drop for any number of cycles; the FSM waits with no timeout.
- `rst` mid-operation: go to IDLE, discard any partial word, issue no write; words already written stay in memory.

## Timing
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
  - `busy`=0, `done`=0, `error`=0.
  - `cpu_hold`=1, `words_loaded`=0.
- All outputs are registered or decoded from the FSM state only, with no combinational path from `in_valid`/`in_data`.
- Write latency: `mem_we` asserts in the cycle after the 4th byte's transfer. `mem_addr` and `mem_wd` are stable throughout that cycle.
- Peak throughput is 4 bytes per 5 cycles.
- `done` and `cpu_hold`=0 take effect in the cycle after the last write, or the cycle after the checksum transfer.
- `error` asserts in the cycle after the offending header or checksum byte.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) covers all data bytes.
  - After the last word (or after the header when N=0), CKSUM accepts one byte.
  - If sum + byte == 0x00, go to DONE; otherwise go to ERR with `cpu_hold` staying 1.
  - Words already written are not rolled back.
- Not defined: no CKSUM state and no sum register; the last write goes directly to DONE.

## Test plan
- Basic load: N=2, data 13 00 00 00 93 00 10 00 → two `mem_we` pulses: addr 0x000 with wd 0x00000013, then addr 0x004 with wd 0x00100093. Then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- N=0 (header 00 00) → no `mem_we`, `done`=1 one cycle after the second header byte (macro off).
- N=257 (header 01 01) → `error`=1, no writes, `in_ready`=0 until the next `start`.
- Full image: N=256 with random `in_valid` gaps → 256 writes, last at 0x3FC, each wd matching its bytes, `done`=1.
- Reset mid-word: `rst` after 2 data bytes → no `mem_we`, IDLE, all outputs at reset values. A subsequent `start` with N=1 writes addr 0x000 correctly.
- Checksum, with the macro defined: N=1, data 01 02 03 04:
  - Checksum byte 0xF6 → `done`=1.
  - Checksum byte 0xF7 → `error`=1 and `cpu_hold`=1, with word 0x04030201 still written at 0x000.
